dmem_arbiter: RTL and testbench

- Shares the single-port data memory (dmem) between two requesters.
- Port 0 is the RVI32 core load/store path. Port 1 is a loader/debug master used for RAM preload, memory dumps and fault injection from the bench.
- Arbitration is round-robin, with locked bursts for port 1 and a starvation guard for the core.
- The block sits between the core/loader and dmem; dmem is unchanged.

---
 rtl/dmem_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data memory between the core load/store path (port 0)
// and a loader/debug master (port 1). Arbitration is round-robin. Port 1 may
// hold the memory for a locked burst, and a starvation guard bounds how long
// the core can be kept waiting.
//
// Ports:
//   CLK, RESET_N                    clock (rising edge), async active-low reset
//   p0_req/we/addr/wdata            core request
//   p0_gnt, p0_rvalid, p0_rdata     core grant and read return (one cycle later)
//   p1_req/we/addr/wdata, p1_lock   loader request and burst lock
//   p1_gnt, p1_rvalid, p1_rdata     loader grant and read return
//   mem_addr, mem_wdata, mem_we     to dmem
//   mem_rdata                       from dmem (combinational read)
//
// Optional feature macro: DMEM_ARB_STATS_EN
//   Adds the wrapping 32-bit counters stat_p0_gnts, stat_p1_gnts and
//   stat_conflicts as output ports.

module dmem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_BURST    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [DATA_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [DATA_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    input  logic                  p1_lock,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]           stat_p0_gnts,
    output logic [31:0]           stat_p1_gnts,
    output logic [31:0]           stat_conflicts
`endif
);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    localparam logic [7:0] LP_MAX_BURST    = 8'(MAX_BURST);
    localparam logic [7:0] LP_STARVE_LIMIT = 8'(STARVE_LIMIT);

    state_t                r_state;
    logic                  r_lastGnt;
    logic [7:0]            r_burstCnt;
    logic [7:0]            r_starveCnt;
    logic [DATA_WIDTH-1:0] r_memAddr;
    logic [DATA_WIDTH-1:0] r_memWdata;
    logic                  r_p0Rvalid;
    logic                  r_p1Rvalid;
    logic [DATA_WIDTH-1:0] r_p0Rdata;
    logic [DATA_WIDTH-1:0] r_p1Rdata;

    state_t                w_nextState;
    logic                  w_nextLastGnt;
    logic [7:0]            w_nextBurst;
    logic [7:0]            w_nextStarve;
    logic                  w_starve;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic [DATA_WIDTH-1:0] w_memAddr;
    logic [DATA_WIDTH-1:0] w_memWdata;

    // Grant decision and next-state logic. Grants are gated with RESET_N so
    // nothing (in particular a write) reaches dmem while reset is asserted.
    // r_lastGnt = 1 means port 1 was served last, so port 0 wins a tie.
    always_comb begin
        w_gnt0        = 1'b0;
        w_gnt1        = 1'b0;
        w_nextState   = r_state;
        w_nextLastGnt = r_lastGnt;
        w_nextBurst   = r_burstCnt;
        w_starve      = p0_req && (r_starveCnt >= LP_STARVE_LIMIT);

        if (RESET_N) begin
            case (r_state)
                ST_ARB: begin
                    if (w_starve) begin
                        w_gnt0 = 1'b1;
                    end else if (p0_req && p1_req) begin
                        w_gnt0 = r_lastGnt;
                        w_gnt1 = !r_lastGnt;
                    end else begin
                        w_gnt0 = p0_req;
                        w_gnt1 = p1_req;
                    end
                    if (w_gnt0) begin
                        w_nextLastGnt = 1'b0;
                    end
                    // A one-beat burst limit never needs the LOCK state.
                    if (w_gnt1) begin
                        w_nextLastGnt = 1'b1;
                        if (p1_lock && (LP_MAX_BURST > 8'd1)) begin
                            w_nextState = ST_LOCK;
                            w_nextBurst = 8'd1;
                        end
                    end
                end
                ST_LOCK: begin
                    if (w_starve) begin
                        w_gnt0        = 1'b1;
                        w_nextState   = ST_ARB;
                        w_nextLastGnt = 1'b1;
                        w_nextBurst   = 8'd0;
                    end else if (p1_req) begin
                        w_gnt1      = 1'b1;
                        w_nextBurst = r_burstCnt + 8'd1;
                        if (!p1_lock || (w_nextBurst >= LP_MAX_BURST)) begin
                            w_nextState   = ST_ARB;
                            w_nextLastGnt = 1'b1;
                            w_nextBurst   = 8'd0;
                        end
                    end else begin
                        w_nextState   = ST_ARB;
                        w_nextLastGnt = 1'b1;
                        w_nextBurst   = 8'd0;
                    end
                end
                default: begin
                    w_nextState = ST_ARB;
                end
            endcase
        end

        // Saturating count of consecutive denied core cycles.
        if (p0_req && !w_gnt0) begin
            w_nextStarve = (r_starveCnt >= LP_STARVE_LIMIT) ? r_starveCnt
                                                            : r_starveCnt + 8'd1;
        end else begin
            w_nextStarve = 8'd0;
        end
    end

    // The memory bus follows the winner; without a grant it holds its last value.
    assign w_memAddr  = w_gnt0 ? p0_addr  : (w_gnt1 ? p1_addr  : r_memAddr);
    assign w_memWdata = w_gnt0 ? p0_wdata : (w_gnt1 ? p1_wdata : r_memWdata);

    assign mem_addr  = w_memAddr;
    assign mem_wdata = w_memWdata;
    assign mem_we    = (w_gnt0 && p0_we) || (w_gnt1 && p1_we);
    assign p0_gnt    = w_gnt0;
    assign p1_gnt    = w_gnt1;
    assign p0_rvalid = r_p0Rvalid;
    assign p1_rvalid = r_p1Rvalid;
    assign p0_rdata  = r_p0Rdata;
    assign p1_rdata  = r_p1Rdata;

    // Arbitration state, held bus values and one-cycle read returns.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= ST_ARB;
            r_lastGnt   <= 1'b1;
            r_burstCnt  <= 8'd0;
            r_starveCnt <= 8'd0;
            r_memAddr   <= '0;
            r_memWdata  <= '0;
            r_p0Rvalid  <= 1'b0;
            r_p1Rvalid  <= 1'b0;
            r_p0Rdata   <= '0;
            r_p1Rdata   <= '0;
        end else begin
            r_state     <= w_nextState;
            r_lastGnt   <= w_nextLastGnt;
            r_burstCnt  <= w_nextBurst;
            r_starveCnt <= w_nextStarve;
            r_memAddr   <= w_memAddr;
            r_memWdata  <= w_memWdata;
            r_p0Rvalid  <= w_gnt0 && !p0_we;
            r_p1Rvalid  <= w_gnt1 && !p1_we;
            if (w_gnt0 && !p0_we) begin
                r_p0Rdata <= mem_rdata;
            end
            if (w_gnt1 && !p1_we) begin
                r_p1Rdata <= mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] r_statP0;
    logic [31:0] r_statP1;
    logic [31:0] r_statConf;

    // Free-running wrapping statistics counters.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_statP0   <= 32'd0;
            r_statP1   <= 32'd0;
            r_statConf <= 32'd0;
        end else begin
            r_statP0   <= r_statP0 + {31'd0, w_gnt0};
            r_statP1   <= r_statP1 + {31'd0, w_gnt1};
            r_statConf <= r_statConf + {31'd0, (p0_req && p1_req)};
        end
    end

    assign stat_p0_gnts   = r_statP0;
    assign stat_p1_gnts   = r_statP1;
    assign stat_conflicts = r_statConf;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a small behavioural dmem attached
// (word-indexed, combinational read, write on the rising edge).
// Inputs change on the falling edge; outputs are sampled 1 ns later.

module tb_dmem_arbiter;

    logic        CLK;
    logic        RESET_N;
    logic        p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_p0_gnts, stat_p1_gnts, stat_conflicts;
`endif

    int checkCount;
    int failCount;
    int weInReset;
    logic [31:0] memArr [0:255];

    dmem_arbiter #(
        .DATA_WIDTH  (32),
        .MAX_BURST   (8),
        .STARVE_LIMIT(4)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .p0_req   (p0_req),
        .p0_we    (p0_we),
        .p0_addr  (p0_addr),
        .p0_wdata (p0_wdata),
        .p0_gnt   (p0_gnt),
        .p0_rvalid(p0_rvalid),
        .p0_rdata (p0_rdata),
        .p1_req   (p1_req),
        .p1_we    (p1_we),
        .p1_addr  (p1_addr),
        .p1_wdata (p1_wdata),
        .p1_lock  (p1_lock),
        .p1_gnt   (p1_gnt),
        .p1_rvalid(p1_rvalid),
        .p1_rdata (p1_rdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_p0_gnts  (stat_p0_gnts),
        .stat_p1_gnts  (stat_p1_gnts),
        .stat_conflicts(stat_conflicts)
`endif
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Behavioural dmem.
    assign mem_rdata = memArr[mem_addr[9:2]];

    always @(posedge CLK) begin
        if (mem_we) begin
            memArr[mem_addr[9:2]] <= mem_wdata;
        end
    end

    // Any write strobe at a clock edge during reset is counted as a violation.
    always @(posedge CLK) begin
        if (!RESET_N && mem_we) begin
            weInReset <= weInReset + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of requests on the falling edge, then settle 1 ns.
    task automatic applyStimulus(input logic r0, input logic we0,
                                 input logic [31:0] a0, input logic [31:0] d0,
                                 input logic r1, input logic we1,
                                 input logic [31:0] a1, input logic [31:0] d1,
                                 input logic lk1);
        @(negedge CLK);
        p0_req   = r0;
        p0_we    = we0;
        p0_addr  = a0;
        p0_wdata = d0;
        p1_req   = r1;
        p1_we    = we1;
        p1_addr  = a1;
        p1_wdata = d1;
        p1_lock  = lk1;
        #1;
    endtask

    task automatic idleInputs;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_lock = 0;
    endtask

    task automatic resetDut;
        RESET_N = 1'b0;
        idleInputs();
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    logic [5:0] contExp0;

    initial begin
        checkCount = 0;
        failCount  = 0;
        weInReset  = 0;
        for (int i = 0; i < 256; i++) memArr[i] = 32'd0;
        RESET_N = 1'b0;
        idleInputs();

        // Reset state, with requests present: nothing may be granted.
        p0_req = 1; p0_we = 1; p0_addr = 32'h44; p1_req = 1; p1_we = 1;
        #2;
        checkOutput("rst_p0_gnt", {31'd0, p0_gnt}, 32'd0);
        checkOutput("rst_p1_gnt", {31'd0, p1_gnt}, 32'd0);
        checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
        checkOutput("rst_p0_rdata", p0_rdata, 32'd0);
        resetDut();

        // Single core traffic: write then read back 0x10.
        applyStimulus(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        checkOutput("sc_wr_gnt", {31'd0, p0_gnt}, 32'd1);
        checkOutput("sc_wr_we", {31'd0, mem_we}, 32'd1);
        checkOutput("sc_wr_addr", mem_addr, 32'h10);
        applyStimulus(1, 0, 32'h10, 32'h0, 0, 0, 0, 0, 0);
        checkOutput("sc_rd_gnt", {31'd0, p0_gnt}, 32'd1);
        checkOutput("sc_rd_we", {31'd0, mem_we}, 32'd0);
        checkOutput("sc_wr_no_rvalid", {31'd0, p0_rvalid}, 32'd0);
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        checkOutput("sc_rvalid", {31'd0, p0_rvalid}, 32'd1);
        checkOutput("sc_rdata", p0_rdata, 32'hDEADBEEF);
        checkOutput("sc_hold_addr", mem_addr, 32'h10);
        checkOutput("sc_p1_gnt", {31'd0, p1_gnt}, 32'd0);
        checkOutput("sc_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
        checkOutput("sc_p1_rdata", p1_rdata, 32'd0);
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        checkOutput("sc_rvalid_once", {31'd0, p0_rvalid}, 32'd0);

        // Contention after reset: grants alternate starting with port 0.
        resetDut();
        contExp0 = 6'b010101;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0, 0);
            checkOutput($sformatf("cont_p0_gnt%0d", i), {31'd0, p0_gnt}, {31'd0, contExp0[i]});
            checkOutput($sformatf("cont_p1_gnt%0d", i), {31'd0, p1_gnt}, {31'd0, !contExp0[i]});
        end
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        checkOutput("cont_p1_rvalid", {31'd0, p1_rvalid}, 32'd1);
`ifdef DMEM_ARB_STATS_EN
        checkOutput("stat_p0_gnts", stat_p0_gnts, 32'd3);
        checkOutput("stat_p1_gnts", stat_p1_gnts, 32'd3);
        checkOutput("stat_conflicts", stat_conflicts, 32'd6);
`endif

        // Locked burst of 8 writes; port 0 asks during beat 8 and must win next.
        resetDut();
        for (int k = 0; k < 8; k++) begin
            applyStimulus((k == 7), 0, 32'h108, 32'h0,
                          1, 1, 32'h100 + 32'(4 * k), 32'hA500_0000 + 32'(k), 1);
            checkOutput($sformatf("burst_p1_gnt%0d", k), {31'd0, p1_gnt}, 32'd1);
            checkOutput($sformatf("burst_addr%0d", k), mem_addr, 32'h100 + 32'(4 * k));
        end
        checkOutput("burst_p0_denied", {31'd0, p0_gnt}, 32'd0);
        applyStimulus(1, 0, 32'h108, 32'h0, 1, 1, 32'h120, 32'hA500_0008, 1);
        checkOutput("burst_exit_p0_gnt", {31'd0, p0_gnt}, 32'd1);
        checkOutput("burst_exit_p1_gnt", {31'd0, p1_gnt}, 32'd0);
        applyStimulus(0, 0, 32'h0, 32'h0, 1, 1, 32'h120, 32'hA500_0008, 1);
        checkOutput("burst_rb_rvalid", {31'd0, p0_rvalid}, 32'd1);
        checkOutput("burst_rb_rdata", p0_rdata, 32'hA500_0002);
        checkOutput("burst_resume_p1", {31'd0, p1_gnt}, 32'd1);
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0);

        // Starvation: port 0 asks at beat 2, denied 4 cycles, granted on the 5th.
        resetDut();
        for (int k = 0; k < 6; k++) begin
            applyStimulus((k >= 1), 0, 32'h100, 32'h0,
                          1, 1, 32'h200 + 32'(4 * k), 32'hC000_0000 + 32'(k), 1);
            if (k < 5) begin
                checkOutput($sformatf("starve_p1_gnt%0d", k), {31'd0, p1_gnt}, 32'd1);
                checkOutput($sformatf("starve_p0_gnt%0d", k), {31'd0, p0_gnt}, 32'd0);
            end else begin
                checkOutput("starve_p0_forced", {31'd0, p0_gnt}, 32'd1);
                checkOutput("starve_p1_held", {31'd0, p1_gnt}, 32'd0);
            end
        end
        applyStimulus(0, 0, 32'h0, 32'h0, 1, 1, 32'h214, 32'hC000_0005, 1);
        checkOutput("starve_rdata", p0_rdata, 32'hA500_0000);
        checkOutput("starve_p1_resume", {31'd0, p1_gnt}, 32'd1);
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0);

        // Reset in the middle of beat 3 of a locked write burst.
        resetDut();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 32'h0, 32'h0,
                          1, 1, 32'h300 + 32'(4 * k), 32'hB000_0000 + 32'(k), 1);
        end
        checkOutput("mid_beat3_gnt", {31'd0, p1_gnt}, 32'd1);
        #1;
        RESET_N = 1'b0;
        #1;
        checkOutput("mid_rst_p1_gnt", {31'd0, p1_gnt}, 32'd0);
        checkOutput("mid_rst_we", {31'd0, mem_we}, 32'd0);
        checkOutput("mid_rst_addr", mem_addr, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("mid_no_we_in_reset", 32'(weInReset), 32'd0);
        checkOutput("mid_beat3_not_written", memArr[8'hC2], 32'd0);
        idleInputs();
        RESET_N = 1'b1;
        applyStimulus(1, 0, 32'h300, 32'h0, 1, 1, 32'h308, 32'hB000_0002, 1);
        checkOutput("mid_after_p0_gnt", {31'd0, p0_gnt}, 32'd1);
        checkOutput("mid_after_p1_gnt", {31'd0, p1_gnt}, 32'd0);
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        checkOutput("mid_after_rdata", p0_rdata, 32'hB000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
